core_mem_arbiter: RTL and testbench

- Shares the single unified memory port of riscv_core between instruction fetch (IF) and the load/store unit (LSU).
- Sits between the core's fetch/LSU request interfaces and the memory model.
- Arbitrates one outstanding transaction at a time and routes each response back to its owner.
- LSU has default priority; a starvation counter guarantees IF forward progress.

---
 rtl/core_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_core_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the load/store unit (LSU).
// One transaction in flight at a time; the LSU wins by default, and a starvation counter guarantees IF progress.
module core_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // debug view of the FSM
  output logic                dbg_busy,
  output logic                dbg_owner_lsu,
  output logic [3:0]          dbg_starve_cnt
);

  // Handshake: a requester holds req (and its fields) until gnt = mem_gnt & selected;
  // exactly one rvalid follows per grant, routed to the owner recorded at grant time.

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LSU = 1'b1} owner_t;

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       sel_if;
  logic       sel_d;
  logic       rsp;

  always_comb begin
    sel_if = 1'b0;
    sel_d  = 1'b0;
    if (!reset && state == IDLE) begin
      if (d_req && starve_cnt < LIMIT) begin
        sel_d = 1'b1;
      end else if (if_req) begin
        sel_if = 1'b1;
      end else if (d_req) begin
        sel_d = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = sel_if | sel_d;
    mem_we    = sel_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (sel_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (sel_if) begin
      mem_addr  = if_addr;
      mem_be    = '1;
    end
    if_gnt = mem_gnt & sel_if;
    d_gnt  = mem_gnt & sel_d;
  end

  // Responses pass straight through; a response seen while IDLE is dropped.
  assign rsp       = !reset && state == BUSY && mem_rvalid;
  assign if_rvalid = rsp && owner == OWN_IF;
  assign d_rvalid  = rsp && owner == OWN_LSU;
  assign if_rdata  = reset ? '0 : mem_rdata;
  assign d_rdata   = reset ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            state <= BUSY;
            owner <= d_gnt ? OWN_LSU : OWN_IF;
          end
        end
        BUSY: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (if_gnt) begin
        starve_cnt <= 4'd0;
      end else if (d_gnt && if_req && starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign dbg_busy       = (state == BUSY);
  assign dbg_owner_lsu  = (owner == OWN_LSU);
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a latency-programmable memory responder,
// expected queues for grants and responses, and a negedge monitor that pops and compares.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b1, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'hCAFE_F00D;
  logic        dbg_busy, dbg_owner_lsu;
  logic [3:0]  dbg_starve_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int lat = 2;

  // grant record: {lsu, we, addr, wdata, be}
  logic [69:0] gnt_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_busy(dbg_busy), .dbg_owner_lsu(dbg_owner_lsu), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0051_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // memory responder: response arrives lat cycles after the accepting cycle
  logic        pend = 1'b0;
  int          left = 0;
  logic [31:0] p_addr = '0;
  always begin
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hCAFE_F00D;
    if (pend) begin
      left--;
      if (left == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_val(p_addr);
        pend       = 1'b0;
      end
    end
    @(negedge clk);
    if (mem_req && mem_gnt) begin
      pend   = 1'b1;
      left   = lat;
      p_addr = mem_addr;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (if_gnt || d_gnt) begin
        check("single_gnt", 160'(if_gnt & d_gnt), 160'(0));
        if (gnt_q.size() == 0) begin
          fail_now("unexpected_gnt");
        end else begin
          logic [69:0] e;
          e = gnt_q.pop_front();
          check("gnt_fields", 160'({d_gnt, mem_we, mem_addr, (d_gnt ? mem_wdata : e[35:4]), mem_be}),
                160'(e));
        end
      end
      if (if_rvalid) begin
        if (exp_if_q.size() == 0) fail_now("unexpected_if_rvalid");
        else check("if_rdata", 160'(if_rdata), 160'(exp_if_q.pop_front()));
      end
      if (d_rvalid) begin
        if (exp_d_q.size() == 0) fail_now("unexpected_d_rvalid");
        else check("d_rdata", 160'(d_rdata), 160'(exp_d_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic exp_if(input logic [31:0] a, input bit resp);
    gnt_q.push_back({1'b0, 1'b0, a, 32'h0, 4'hF});
    if (resp) exp_if_q.push_back(mem_val(a));
  endtask

  task automatic exp_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    gnt_q.push_back({1'b1, we, a, wd, be});
    exp_d_q.push_back(mem_val(a));
  endtask

  task automatic if_drive(input logic [31:0] a);
    int t;
    t = 0;
    if_req  = 1'b1;
    if_addr = a;
    forever begin
      @(negedge clk);
      if (if_gnt) break;
      t++;
      if (t >= 200) begin fail_now("if_gnt_timeout"); break; end
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic d_drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int t;
    t = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    forever begin
      @(negedge clk);
      if (d_gnt) break;
      t++;
      if (t >= 200) begin fail_now("d_gnt_timeout"); break; end
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!dbg_busy && !pend && exp_if_q.size() == 0 && exp_d_q.size() == 0) break;
      t++;
      if (t >= 200) begin fail_now("idle_timeout"); break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 160'({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we,
                      mem_addr, mem_wdata, mem_be, dbg_busy, dbg_owner_lsu, dbg_starve_cnt}), 160'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // wait for a grant on one side, bounded
  task automatic wait_gnt(input bit lsu, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (lsu ? d_gnt : if_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("gnt_wait_timeout");
  endtask

  initial begin
    bit ok;
    int t;

    // reset state
    @(negedge clk);
    check_all_zero("initial_reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_state", 160'({dbg_busy, dbg_owner_lsu, dbg_starve_cnt, mem_req}), 160'(0));

    // single IF read, latency 2
    do_reset();
    lat = 2;
    exp_if(32'h0000_0010, 1'b1);
    fork
      if_drive(32'h0000_0010);
      begin
        wait_gnt(1'b0, ok);
        t = 0;
        while (ok && t < 50) begin
          @(negedge clk);
          t++;
          if (if_rvalid) break;
        end
        check("if_latency", 160'(t), 160'(2));
      end
    join
    wait_idle();

    // simultaneous IF and LSU after reset: LSU first, IF right after the response
    do_reset();
    lat = 2;
    exp_d(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    exp_if(32'h0000_0020, 1'b1);
    fork
      if_drive(32'h0000_0020);
      d_drive(1'b0, 32'h0000_0100, 32'h0, 4'hF);
      begin
        wait_gnt(1'b1, ok);
        @(negedge clk);
        check("starve_after_d", 160'(dbg_starve_cnt), 160'(1));
        t = 1;
        while (ok && t < 50 && !if_gnt) begin
          @(negedge clk);
          t++;
        end
        check("d_to_if_gap", 160'(t), 160'(3));
        @(negedge clk);
        check("starve_after_if", 160'(dbg_starve_cnt), 160'(0));
      end
    join
    wait_idle();

    // starvation: four LSU grants, then IF, then LSU again
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) exp_d(1'b0, 32'h0000_0300 + 32'(4 * i), 32'h0, 4'hF);
    exp_if(32'h0000_0040, 1'b1);
    for (int i = 4; i < 6; i++) exp_d(1'b0, 32'h0000_0300 + 32'(4 * i), 32'h0, 4'hF);
    fork
      if_drive(32'h0000_0040);
      for (int i = 0; i < 6; i++) d_drive(1'b0, 32'h0000_0300 + 32'(4 * i), 32'h0, 4'hF);
      begin
        for (int k = 0; k < 4; k++) wait_gnt(1'b1, ok);
        @(negedge clk);
        check("starve_saturated", 160'(dbg_starve_cnt), 160'(4));
      end
    join
    wait_idle();
    check("starve_cleared", 160'(dbg_starve_cnt), 160'(0));

    // LSU partial write
    do_reset();
    lat = 3;
    exp_d(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
    d_drive(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
    wait_idle();

    // memory stalls the grant for three cycles
    do_reset();
    lat = 2;
    mem_gnt = 1'b0;
    exp_d(1'b0, 32'h0000_0400, 32'h1234_5678, 4'hF);
    fork
      d_drive(1'b0, 32'h0000_0400, 32'h1234_5678, 4'hF);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_no_gnt", 160'({d_gnt, if_gnt, dbg_busy}), 160'(0));
          check("stall_fields", 160'({mem_req, mem_we, mem_addr, mem_wdata, mem_be}),
                160'({1'b1, 1'b0, 32'h0000_0400, 32'h1234_5678, 4'hF}));
        end
        @(posedge clk);
        #1;
        mem_gnt = 1'b1;
      end
    join
    wait_idle();

    // reset during BUSY; the late response must be dropped
    do_reset();
    lat = 4;
    exp_if(32'h0000_0050, 1'b0);
    if_drive(32'h0000_0050);
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0060;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
    @(negedge clk);
    check_all_zero("busy_reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_rvalid) begin
        ok = 1'b1;
        check("late_rvalid_dropped", 160'({if_rvalid, d_rvalid}), 160'(0));
      end
    end
    if (!ok) fail_now("late_rvalid_missing");
    @(posedge clk);
    #1;
    lat = 2;
    exp_if(32'h0000_0070, 1'b1);
    if_drive(32'h0000_0070);
    wait_idle();

    // final report
    check("gnt_q_drained", 160'(gnt_q.size()), 160'(0));
    check("if_q_drained", 160'(exp_if_q.size()), 160'(0));
    check("d_q_drained", 160'(exp_d_q.size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
